// File: rtl/conv_frame_drain.sv
// ---- conv_frame_drain : captures one conv-result frame, clamps each result to a pixel,
// ---- then streams the frame out on a valid/ready port with row/frame markers (rev 1.0)
`default_nettype none

module conv_frame_drain #(
  parameter int DATA_W  = 32,
  parameter int PIX_W   = 8,
  parameter int SHIFT   = 0,
  parameter int MAX_PIX = 576
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              state,
  input  logic [DATA_W-1:0] din,
  input  logic              ivalid,
  input  logic              idone,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [PIX_W-1:0]  rd_data,
  output logic              rd_eol,
  output logic              rd_last,
  output logic              busy,
  output logic              err
);

  localparam int AW = $clog2(MAX_PIX + 2);
  localparam int MW = $clog2(MAX_PIX);
  localparam logic [AW-1:0] C_N_BIG   = AW'(MAX_PIX);
  localparam logic [AW-1:0] C_N_SMALL = AW'(64);
  localparam logic [4:0]    C_ROW_BIG_M1   = 5'd23;
  localparam logic [4:0]    C_ROW_SMALL_M1 = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              size_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [4:0]        col_q;
  logic              err_q;
  logic              s1_valid_q, s1_eol_q, s1_last_q;
  logic [PIX_W-1:0]  s1_data_q;
  logic              rd_valid_q, rd_eol_q, rd_last_q;
  logic [PIX_W-1:0]  rd_data_q;
  logic [PIX_W-1:0]  mem_q [MAX_PIX];

  logic [AW-1:0]            w_n;
  logic [4:0]               w_row_m1;
  logic [AW-1:0]            w_count;
  logic signed [DATA_W-1:0] w_shifted;
  logic [PIX_W-1:0]         w_pix;
  logic                     w_wr_en, w_xfer, w_done, w_adv, w_s1_en, w_fetch;

  assign w_n      = size_q ? C_N_SMALL : C_N_BIG;
  assign w_row_m1 = size_q ? C_ROW_SMALL_M1 : C_ROW_BIG_M1;
  assign w_count  = wr_ptr_q + AW'(1);

  assign w_shifted = $signed(din) >>> SHIFT;
  always_comb begin
    w_pix = w_shifted[PIX_W-1:0];
    if (w_shifted[DATA_W-1]) begin
      w_pix = '0;
    end else if (|w_shifted[DATA_W-1:PIX_W]) begin
      w_pix = '1;
    end
  end

  // wr_ptr_q is always 0 in IDLE, so it doubles as the write address there
  assign w_wr_en = ivalid && ((state_q == ST_IDLE) ||
                              ((state_q == ST_CAPTURE) && (wr_ptr_q < w_n)));

  // Two-stage read pipeline (RAM register, output register) that only stalls when full
  assign w_xfer  = rd_valid_q && rd_ready;
  assign w_done  = w_xfer && rd_last_q;
  assign w_adv   = !rd_valid_q || rd_ready;
  assign w_s1_en = !s1_valid_q || w_adv;
  assign w_fetch = (state_q == ST_DRAIN) && w_s1_en && (rd_ptr_q < w_n);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (ivalid && !idone) state_d = ST_CAPTURE;
      ST_CAPTURE: if (ivalid && idone)  state_d = (w_count == w_n) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN:   if (w_done)           state_d = ST_IDLE;
      default:                          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) mem_q[wr_ptr_q[MW-1:0]] <= w_pix;
    if (w_fetch) s1_data_q <= mem_q[rd_ptr_q[MW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      size_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      col_q      <= '0;
      err_q      <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_eol_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_eol_q   <= 1'b0;
      rd_last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          size_q <= state;
          if (ivalid) begin
            err_q    <= idone;
            wr_ptr_q <= idone ? '0 : AW'(1);
          end
        end
        ST_CAPTURE: begin
          if (ivalid) begin
            if (wr_ptr_q >= w_n) err_q <= 1'b1;
            if (idone) begin
              wr_ptr_q <= '0;
              if (w_count != w_n) err_q <= 1'b1;
            end else if (wr_ptr_q <= w_n) begin
              // Saturate one past N so a long frame can never wrap back to N
              wr_ptr_q <= w_count;
            end
          end
        end
        ST_DRAIN: begin
          if (ivalid) err_q <= 1'b1;
        end
        default: ;
      endcase

      if (w_s1_en) begin
        s1_valid_q <= w_fetch;
        if (w_fetch) begin
          s1_eol_q  <= (col_q == w_row_m1);
          s1_last_q <= (rd_ptr_q == w_n - AW'(1));
          rd_ptr_q  <= rd_ptr_q + AW'(1);
          col_q     <= (col_q == w_row_m1) ? 5'd0 : col_q + 5'd1;
        end
      end

      if (w_adv) begin
        rd_valid_q <= s1_valid_q;
        rd_data_q  <= s1_data_q;
        rd_eol_q   <= s1_eol_q;
        rd_last_q  <= s1_last_q;
      end

      if (w_done) begin
        rd_valid_q <= 1'b0;
        rd_ptr_q   <= '0;
        col_q      <= '0;
      end
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_eol   = rd_eol_q;
  assign rd_last  = rd_last_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_conv_frame_drain.sv
// ---- tb_conv_frame_drain : scoreboard bench for conv_frame_drain (SHIFT=0 and SHIFT=2 instances)
`default_nettype none

module tb_conv_frame_drain;

  logic        clk = 1'b0;
  logic        rstn;
  logic        state;
  logic [31:0] din;
  logic        ivalid, idone, rd_ready;
  logic        sel;

  logic       v0, e0, l0, b0, r0;
  logic [7:0] d0;
  logic       v1, e1, l1, b1, r1;
  logic [7:0] d1;

  logic       m_valid, m_eol, m_last, m_busy, m_err;
  logic [7:0] m_data;

  typedef struct packed {
    logic [7:0] d;
    logic       eol;
    logic       last;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] frame_d [600];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_xfer = 0;
  int          cyc = 0;
  int          last_xfer_cyc = 0;

  logic       stall_q = 1'b0;
  logic [7:0] h_data;
  logic       h_eol, h_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_frame_drain #(.DATA_W(32), .PIX_W(8), .SHIFT(0), .MAX_PIX(576)) u_dut0 (
    .clk(clk), .rstn(rstn), .state(state), .din(din),
    .ivalid(ivalid && !sel), .idone(idone), .rd_ready(rd_ready),
    .rd_valid(v0), .rd_data(d0), .rd_eol(e0), .rd_last(l0), .busy(b0), .err(r0));

  conv_frame_drain #(.DATA_W(32), .PIX_W(8), .SHIFT(2), .MAX_PIX(576)) u_dut2 (
    .clk(clk), .rstn(rstn), .state(state), .din(din),
    .ivalid(ivalid && sel), .idone(idone), .rd_ready(rd_ready),
    .rd_valid(v1), .rd_data(d1), .rd_eol(e1), .rd_last(l1), .busy(b1), .err(r1));

  assign m_valid = sel ? v1 : v0;
  assign m_data  = sel ? d1 : d0;
  assign m_eol   = sel ? e1 : e0;
  assign m_last  = sel ? l1 : l0;
  assign m_busy  = sel ? b1 : b0;
  assign m_err   = sel ? r1 : r0;

  function automatic logic [7:0] ref_pix(input logic [31:0] d, input int sh);
    longint v;
    v = longint'($signed(d)) >>> sh;
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  // Output monitor: every transfer pops the scoreboard; stalled outputs must hold
  always @(negedge clk) begin
    if (!rstn) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        n_vec++;
        if (!(m_valid === 1'b1 && m_data === h_data && m_eol === h_eol && m_last === h_last)) begin
          n_err++;
          $display("FAIL hold: got v=%b d=%0d eol=%b last=%b, need v=1 d=%0d eol=%b last=%b",
                   m_valid, m_data, m_eol, m_last, h_data, h_eol, h_last);
        end
      end
      if (m_valid === 1'b1 && rd_ready) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_pixel: got d=%0d, need no output", m_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (m_data !== e.d || m_eol !== e.eol || m_last !== e.last) begin
            n_err++;
            $display("FAIL pixel #%0d: got d=%0d eol=%b last=%b, need d=%0d eol=%b last=%b",
                     n_xfer, m_data, m_eol, m_last, e.d, e.eol, e.last);
          end
        end
        n_xfer++;
        last_xfer_cyc = cyc;
      end
      stall_q = (m_valid === 1'b1) && !rd_ready;
      h_data  = m_data;
      h_eol   = m_eol;
      h_last  = m_last;
    end
  end

  task automatic send_frame(input int n, input bit sz, input bit push, input bit gaps,
                            input bit flip, input bit chk_clr);
    int row;
    row = sz ? 8 : 24;
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        ivalid = 1'b0;
        idone  = 1'b0;
      end
      @(posedge clk); #1;
      if (chk_clr && k == 1) begin
        n_vec++;
        if (m_err !== 1'b0) begin
          n_err++;
          $display("FAIL err_clear: got err=%b, need 0", m_err);
        end
      end
      state  = (flip && k > 0) ? !sz : sz;
      ivalid = 1'b1;
      din    = frame_d[k];
      idone  = (k == n - 1);
      if (push) begin
        exp_t e;
        e.d    = ref_pix(frame_d[k], sel ? 2 : 0);
        e.eol  = ((k + 1) % row) == 0;
        e.last = (k == n - 1);
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    ivalid = 1'b0;
    idone  = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!m_busy && sb.size() == 0) break;
    end
    n_vec++;
    if (m_busy !== 1'b0 || sb.size() != 0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drain_done: got busy=%b valid=%b pending=%0d, need 0/0/0",
               m_busy, m_valid, sb.size());
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      n_vec++;
      if ({m_valid, m_data, m_eol, m_last, m_busy, m_err} !== 13'd0) begin
        n_err++;
        $display("FAIL reset_outputs dut%0d: got %h, need 0", s,
                 {m_valid, m_data, m_eol, m_last, m_busy, m_err});
      end
    end
    sel = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_full_frame;
    int t_first;
    sel = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 576; k++) frame_d[k] = k;
    send_frame(576, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: got rd_valid=%b one cycle after idone, need 0", m_valid);
    end
    @(negedge clk);
    t_first = cyc;
    n_vec++;
    if (m_valid !== 1'b1 || m_busy !== 1'b1) begin
      n_err++;
      $display("FAIL latency: got rd_valid=%b busy=%b two cycles after idone, need 1/1",
               m_valid, m_busy);
    end
    wait_drain(2000);
    n_vec++;
    if (last_xfer_cyc - t_first != 575 || m_err !== 1'b0) begin
      n_err++;
      $display("FAIL throughput: got span=%0d err=%b, need 575/0", last_xfer_cyc - t_first, m_err);
    end
  endtask

  task automatic test_shift_small;
    sel = 1'b1;
    #1;
    frame_d[0] = -32'sd8;
    frame_d[1] = 32'd3;
    frame_d[2] = 32'd1023;
    frame_d[3] = 32'd400;
    frame_d[4] = 32'h7fff_ffff;
    frame_d[5] = 32'h8000_0000;
    frame_d[6] = 32'd1020;
    frame_d[7] = 32'd1019;
    for (int k = 8; k < 64; k++) frame_d[k] = $urandom_range(0, 2400) - 1000;
    send_frame(64, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    wait_drain(500);
    n_vec++;
    if (m_err !== 1'b0) begin
      n_err++;
      $display("FAIL shift_err: got err=%b, need 0", m_err);
    end
    sel = 1'b0;
    #1;
  endtask

  task automatic test_backpressure;
    logic [3:0] pat;
    pat = 4'b1001;
    sel = 1'b0;
    for (int k = 0; k < 64; k++) frame_d[k] = $urandom;
    for (int k = 0; k < 8; k++) frame_d[k * 8] = $urandom_range(0, 300);
    fork
      send_frame(64, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      begin
        for (int w = 0; w < 300 && m_valid !== 1'b1; w++) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
          rd_ready = (i < 4) ? pat[i] : 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        rd_ready = 1'b1;
      end
    join
    wait_drain(500);
  endtask

  task automatic test_short_frame;
    sel = 1'b0;
    for (int k = 0; k < 64; k++) frame_d[k] = k + 10;
    send_frame(60, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_vec++;
    if (m_err !== 1'b1 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL short_frame: got err=%b busy=%b valid=%b, need 1/0/0", m_err, m_busy, m_valid);
    end
    send_frame(64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_drain(500);
  endtask

  task automatic test_long_frame;
    sel = 1'b0;
    for (int k = 0; k < 70; k++) frame_d[k] = k;
    send_frame(70, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_vec++;
    if (m_err !== 1'b1 || m_busy !== 1'b0 || m_valid !== 1'b0) begin
      n_err++;
      $display("FAIL long_frame: got err=%b busy=%b valid=%b, need 1/0/0", m_err, m_busy, m_valid);
    end
  endtask

  task automatic test_overrun;
    sel = 1'b0;
    for (int k = 0; k < 64; k++) frame_d[k] = $urandom_range(0, 255);
    send_frame(64, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 3; p++) begin
      repeat (3) @(posedge clk);
      #1;
      ivalid = 1'b1;
      idone  = (p == 2);
      din    = 32'hdead_0000 + p;
      @(posedge clk); #1;
      ivalid = 1'b0;
      idone  = 1'b0;
    end
    @(negedge clk);
    n_vec++;
    if (m_err !== 1'b1 || m_busy !== 1'b1) begin
      n_err++;
      $display("FAIL overrun: got err=%b busy=%b, need 1/1", m_err, m_busy);
    end
    wait_drain(500);
  endtask

  task automatic test_reset_mid_drain;
    int base;
    sel = 1'b0;
    rd_ready = 1'b1;
    for (int k = 0; k < 576; k++) frame_d[k] = $urandom_range(0, 600);
    base = n_xfer;
    send_frame(576, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2000 && n_xfer < base + 100; i++) @(negedge clk);
    rstn = 1'b0;
    sb.delete();
    @(negedge clk);
    n_vec++;
    if ({m_valid, m_data, m_eol, m_last, m_busy, m_err} !== 13'd0) begin
      n_err++;
      $display("FAIL reset_mid_drain: got %h, need 0", {m_valid, m_data, m_eol, m_last, m_busy, m_err});
    end
    rstn = 1'b1;
    for (int k = 0; k < 576; k++) frame_d[k] = 575 - k;
    send_frame(576, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_drain(2000);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn     = 1'b0;
    state    = 1'b0;
    din      = '0;
    ivalid   = 1'b0;
    idone    = 1'b0;
    rd_ready = 1'b1;
    sel      = 1'b0;
    test_reset;
    test_full_frame;
    test_shift_small;
    test_backpressure;
    test_short_frame;
    test_long_frame;
    test_overrun;
    test_reset_mid_drain;
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
